// File: rtl/traffic_sequencer_pkg.sv
// Purpose: shared constants, FSM encoding and speed clamp for the road-lane sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package traffic_sequencer_pkg;

  localparam int SCREEN_W_DEF  = 640;
  localparam int DIV_COUNT_DEF = 250000;
  localparam int MAX_SPD       = 15;

  // Lane start positions, lanes 3..0 (reload value on reset/restart).
  localparam logic [3:0][9:0] INIT_X   = {10'd500, 10'd320, 10'd608, 10'd100};
  // Base pixels per tick, lanes 3..0.
  localparam logic [3:0][3:0] BASE_SPD = {4'd3, 4'd1, 4'd2, 4'd1};
  // 1 = lane moves left, 0 = lane moves right (lanes 3..0).
  localparam logic [3:0]      LANE_DIR = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L0   = 3'd1,
    ST_L1   = 3'd2,
    ST_L2   = 3'd3,
    ST_L3   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Lane speed is base plus level, saturated to the 4-bit maximum.
  function automatic logic [3:0] clamp_speed(input logic [3:0] base, input logic [2:0] level);
    logic [4:0] sum;
    sum = {1'b0, base} + {2'b00, level};
    return (sum > 5'(MAX_SPD)) ? 4'(MAX_SPD) : sum[3:0];
  endfunction

endpackage

// File: rtl/traffic_sequencer_car_lane_step.sv
// Purpose: one wrap-around position step for a single lane, shared across all lanes.
// Latency: combinational.
// Backpressure: none.
module traffic_sequencer_car_lane_step #(
  parameter int SCREEN_W = 640
) (
  input  logic [9:0] x,
  input  logic [3:0] s,
  input  logic       dir,
  output logic [9:0] x_next
);

  localparam logic [10:0] W11 = 11'(SCREEN_W);

  logic [10:0] sum;
  logic [9:0]  s10;

  // Right moves add and subtract the width once on overflow; left moves borrow the width on underflow.
  always_comb begin
    sum    = {1'b0, x} + {7'd0, s};
    s10    = {6'd0, s};
    x_next = 10'd0;
    if (!dir) begin
      x_next = (sum >= W11) ? 10'(sum - W11) : sum[9:0];
    end else if (x < s10) begin
      x_next = 10'({1'b0, x} + W11 - {7'd0, s});
    end else begin
      x_next = x - s10;
    end
  end

endmodule

// File: rtl/traffic_sequencer.sv
// Purpose: tick divider plus a lane-sweep FSM that moves four car lanes through one shared step unit.
// Latency: lane k updated k+2 cycles after the tick cycle; frame-done pulse 5 cycles after tick.
// Backpressure: i_pause holds the divider while idle; a started sweep always completes.
module traffic_sequencer
  import traffic_sequencer_pkg::*;
#(
  parameter int DIV_COUNT = DIV_COUNT_DEF,
  parameter int SCREEN_W  = SCREEN_W_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_pause,
  input  logic       i_restart,
  input  logic [2:0] i_level,
  output logic [9:0] car_x1,
  output logic [9:0] car_x2,
  output logic [9:0] car_x3,
  output logic [9:0] car_x4,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int            DW       = $clog2(DIV_COUNT);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COUNT - 1);

  state_t          state, state_n;
  logic [DW-1:0]   div_cnt;
  logic [2:0]      level_q;
  logic [3:0][9:0] lane_x;
  logic [1:0]      lane_sel;
  logic            lane_wr;
  logic            tick;
  logic [9:0]      step_x;

  assign tick = (div_cnt == DIV_LAST) && !i_pause && (state == ST_IDLE);

  // Next state, lane select and status outputs; restart forces the FSM back to idle.
  always_comb begin
    state_n      = state;
    lane_sel     = 2'd0;
    lane_wr      = 1'b0;
    o_busy       = 1'b1;
    o_frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (tick) state_n = ST_L0;
      end
      ST_L0: begin lane_sel = 2'd0; lane_wr = 1'b1; state_n = ST_L1; end
      ST_L1: begin lane_sel = 2'd1; lane_wr = 1'b1; state_n = ST_L2; end
      ST_L2: begin lane_sel = 2'd2; lane_wr = 1'b1; state_n = ST_L3; end
      ST_L3: begin lane_sel = 2'd3; lane_wr = 1'b1; state_n = ST_DONE; end
      ST_DONE: begin
        o_frame_done = 1'b1;
        state_n      = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (i_restart) state_n = ST_IDLE;
  end

  // FSM register, movement divider and per-sweep level latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      level_q <= 3'd0;
    end else begin
      state <= state_n;
      if (i_restart) begin
        div_cnt <= '0;
      end else if (!(i_pause && state == ST_IDLE)) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      end
      if (tick && !i_restart) level_q <= i_level;
    end
  end

  traffic_sequencer_car_lane_step #(.SCREEN_W(SCREEN_W)) u_step (
    .x      (lane_x[lane_sel]),
    .s      (clamp_speed(BASE_SPD[lane_sel], level_q)),
    .dir    (LANE_DIR[lane_sel]),
    .x_next (step_x)
  );

  // Lane position registers: reload on reset/restart, otherwise write the lane selected by the sweep.
  always_ff @(posedge CLK) begin
    if (RST || i_restart) begin
      lane_x <= INIT_X;
    end else if (lane_wr) begin
      lane_x[lane_sel] <= step_x;
    end
  end

  assign car_x1 = lane_x[0];
  assign car_x2 = lane_x[1];
  assign car_x3 = lane_x[2];
  assign car_x4 = lane_x[3];

endmodule

// File: tb/tb_traffic_sequencer.sv
// Purpose: directed self-checking bench for the lane sequencer with a short tick divider.
// Latency: checks tick spacing, per-lane write timing and frame-done pulse position.
// Backpressure: exercises pause, restart and reset in the middle of a sweep.
module tb_traffic_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       i_pause = 1'b0;
  logic       i_restart = 1'b0;
  logic [2:0] i_level = 3'd0;
  logic [9:0] car_x1, car_x2, car_x3, car_x4;
  logic       o_busy, o_frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_sequencer #(.DIV_COUNT(8), .SCREEN_W(640)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .i_pause      (i_pause),
    .i_restart    (i_restart),
    .i_level      (i_level),
    .car_x1       (car_x1),
    .car_x2       (car_x2),
    .car_x3       (car_x3),
    .car_x4       (car_x4),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Edges until o_busy rises (tick edge); gives up at 64 edges so the caller sees a wrong count.
  task automatic wait_tick(output int n);
    n = 0;
    while (!o_busy && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic run_sweep(input logic [2:0] lvl, output int n);
    i_level = lvl;
    wait_tick(n);
    repeat (5) step();
  endtask

  task automatic test_reset();
    int n;
    RST = 1'b1;
    repeat (3) step();
    n_checks++; if (car_x1 !== 10'd100) begin n_fail++; $display("FAIL reset_x1 got %0d want 100", car_x1); end
    n_checks++; if (car_x2 !== 10'd608) begin n_fail++; $display("FAIL reset_x2 got %0d want 608", car_x2); end
    n_checks++; if (car_x3 !== 10'd320) begin n_fail++; $display("FAIL reset_x3 got %0d want 320", car_x3); end
    n_checks++; if (car_x4 !== 10'd500) begin n_fail++; $display("FAIL reset_x4 got %0d want 500", car_x4); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_checks++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", o_frame_done); end
    RST = 1'b0;
    wait_tick(n);
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL first_tick edges got %0d want 8", n); end
  endtask

  // Called right at the tick edge of the first sweep (level 0).
  task automatic test_single_sweep();
    step();
    n_checks++; if (car_x1 !== 10'd101) begin n_fail++; $display("FAIL sweep_x1 got %0d want 101", car_x1); end
    repeat (2) step();
    n_checks++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL done_early got %b want 0", o_frame_done); end
    step();
    n_checks++; if (o_frame_done !== 1'b1) begin n_fail++; $display("FAIL done_pulse got %b want 1", o_frame_done); end
    n_checks++; if (car_x2 !== 10'd606) begin n_fail++; $display("FAIL sweep_x2 got %0d want 606", car_x2); end
    n_checks++; if (car_x3 !== 10'd321) begin n_fail++; $display("FAIL sweep_x3 got %0d want 321", car_x3); end
    n_checks++; if (car_x4 !== 10'd497) begin n_fail++; $display("FAIL sweep_x4 got %0d want 497", car_x4); end
    step();
    n_checks++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL done_late got %b want 0", o_frame_done); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after got %b want 0", o_busy); end
  endtask

  task automatic test_wrap();
    int n;
    for (int i = 0; i < 67; i++) begin
      run_sweep(3'd7, n);
      n_checks++; if (n !== 3) begin n_fail++; $display("FAIL period sweep %0d edges got %0d want 3", i, n); end
    end
    n_checks++; if (car_x1 !== 10'd637) begin n_fail++; $display("FAIL lvl7_x1 got %0d want 637", car_x1); end
    n_checks++; if (car_x2 !== 10'd3)   begin n_fail++; $display("FAIL lvl7_x2 got %0d want 3", car_x2); end
    n_checks++; if (car_x3 !== 10'd217) begin n_fail++; $display("FAIL lvl7_x3 got %0d want 217", car_x3); end
    n_checks++; if (car_x4 !== 10'd467) begin n_fail++; $display("FAIL lvl7_x4 got %0d want 467", car_x4); end
    run_sweep(3'd0, n);
    n_checks++; if (car_x1 !== 10'd638) begin n_fail++; $display("FAIL pre_x1 got %0d want 638", car_x1); end
    n_checks++; if (car_x2 !== 10'd1)   begin n_fail++; $display("FAIL pre_x2 got %0d want 1", car_x2); end
    run_sweep(3'd2, n);
    n_checks++; if (car_x1 !== 10'd1)   begin n_fail++; $display("FAIL wrap_right_x1 got %0d want 1", car_x1); end
    n_checks++; if (car_x2 !== 10'd637) begin n_fail++; $display("FAIL wrap_left_x2 got %0d want 637", car_x2); end
    n_checks++; if (car_x3 !== 10'd221) begin n_fail++; $display("FAIL wrap_x3 got %0d want 221", car_x3); end
    n_checks++; if (car_x4 !== 10'd459) begin n_fail++; $display("FAIL wrap_x4 got %0d want 459", car_x4); end
  endtask

  task automatic test_level_latch();
    int n;
    i_level = 3'd7;
    wait_tick(n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL latch_tick edges got %0d want 3", n); end
    step();
    i_level = 3'd5;
    repeat (3) step();
    n_checks++; if (car_x4 !== 10'd449) begin n_fail++; $display("FAIL latch_x4 got %0d want 449", car_x4); end
    n_checks++; if (car_x1 !== 10'd9)   begin n_fail++; $display("FAIL latch_x1 got %0d want 9", car_x1); end
    n_checks++; if (car_x2 !== 10'd628) begin n_fail++; $display("FAIL latch_x2 got %0d want 628", car_x2); end
    n_checks++; if (car_x3 !== 10'd229) begin n_fail++; $display("FAIL latch_x3 got %0d want 229", car_x3); end
    step();
    wait_tick(n);
    repeat (5) step();
    n_checks++; if (car_x4 !== 10'd441) begin n_fail++; $display("FAIL lvl5_x4 got %0d want 441", car_x4); end
    n_checks++; if (car_x1 !== 10'd15)  begin n_fail++; $display("FAIL lvl5_x1 got %0d want 15", car_x1); end
  endtask

  task automatic test_pause();
    int n;
    logic bad;
    wait_tick(n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL pause_tick edges got %0d want 3", n); end
    step();
    i_pause = 1'b1;
    repeat (3) step();
    n_checks++; if (o_frame_done !== 1'b1) begin n_fail++; $display("FAIL pause_done got %b want 1", o_frame_done); end
    n_checks++; if (car_x4 !== 10'd433) begin n_fail++; $display("FAIL pause_x4 got %0d want 433", car_x4); end
    n_checks++; if (car_x2 !== 10'd614) begin n_fail++; $display("FAIL pause_x2 got %0d want 614", car_x2); end
    step();
    bad = 1'b0;
    repeat (20) begin
      step();
      if (o_busy !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL paused_tick got %b want 0", bad); end
    i_pause = 1'b0;
    wait_tick(n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL resume_edges got %0d want 3", n); end
    repeat (5) step();
    n_checks++; if (car_x1 !== 10'd27) begin n_fail++; $display("FAIL resume_x1 got %0d want 27", car_x1); end
  endtask

  task automatic test_restart();
    int n;
    logic bad;
    wait_tick(n);
    repeat (2) step();
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    i_level = 3'd0;
    n_checks++; if (car_x1 !== 10'd100) begin n_fail++; $display("FAIL rst_x1 got %0d want 100", car_x1); end
    n_checks++; if (car_x2 !== 10'd608) begin n_fail++; $display("FAIL rst_x2 got %0d want 608", car_x2); end
    n_checks++; if (car_x3 !== 10'd320) begin n_fail++; $display("FAIL rst_x3 got %0d want 320", car_x3); end
    n_checks++; if (car_x4 !== 10'd500) begin n_fail++; $display("FAIL rst_x4 got %0d want 500", car_x4); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", o_busy); end
    bad = 1'b0;
    repeat (7) begin
      step();
      if (o_busy !== 1'b0 || o_frame_done !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rst_quiet got %b want 0", bad); end
    step();
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rst_next_tick got %b want 1", o_busy); end
    repeat (3) step();
    RST = 1'b1;
    step();
    n_checks++; if (car_x1 !== 10'd100) begin n_fail++; $display("FAIL hrst_x1 got %0d want 100", car_x1); end
    n_checks++; if (car_x4 !== 10'd500) begin n_fail++; $display("FAIL hrst_x4 got %0d want 500", car_x4); end
    n_checks++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL hrst_done got %b want 0", o_frame_done); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL hrst_busy got %b want 0", o_busy); end
    step();
    RST = 1'b0;
    wait_tick(n);
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL hrst_tick edges got %0d want 8", n); end
    step();
    n_checks++; if (car_x1 !== 10'd101) begin n_fail++; $display("FAIL hrst_sweep_x1 got %0d want 101", car_x1); end
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_wrap();
    test_level_latch();
    test_pause();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
